// File: rtl/color_label_encoder.sv
// ---------------------------------------------------------------------------
// color_label_encoder
//
// Classifies each camera pixel into a coarse colour label (blue, green, red,
// purple, orange, yellow or none) and forwards the video timing, pixel
// column/row indices and a 3-bit frame counter, all aligned with the label.
// The pipeline has a fixed latency and no backpressure: the input register
// samples a pixel at edge N, and the result is on every o_* port after edge N+3.
//
// Pipeline:
//   in : i_rgb / sync / de captured, column and row counters updated
//   s1 : R, G, B, max(R,G,B), min(R,G,B)
//   s2 : delta = max-min, dominant channel
//   s3 : label decision, registered outputs, frame counter
//
// Ports:
//   pixelclk      in   pixel clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   i_rgb[23:0]   in   {R, G, B} pixel
//   i_hsync       in   horizontal sync
//   i_vsync       in   vertical sync, active high
//   i_de          in   data enable, high on active pixels
//   o_label[23:0] out  colour label (24'h000000 when o_de = 0)
//   o_hsync       out  i_hsync aligned with o_label
//   o_vsync       out  i_vsync aligned with o_label
//   o_de          out  i_de aligned with o_label
//   o_hcount[11:0] out column of the pixel on o_label (0 when o_de = 0)
//   o_vcount[11:0] out row of the pixel on o_label
//   o_frame_cnt[2:0] out frame counter, steps with the aligned o_vsync rise
// ---------------------------------------------------------------------------
module color_label_encoder #(
  parameter logic [7:0] SAT_TH = 8'd40,
  parameter logic [7:0] VAL_TH = 8'd50
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic [23:0] i_rgb,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  output logic [23:0] o_label,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_hcount,
  output logic [11:0] o_vcount,
  output logic [2:0]  o_frame_cnt
);

  localparam logic [23:0] LBL_NONE   = 24'h000000;
  localparam logic [23:0] LBL_BLUE   = 24'h111111;
  localparam logic [23:0] LBL_GREEN  = 24'h222222;
  localparam logic [23:0] LBL_RED    = 24'h333333;
  localparam logic [23:0] LBL_PURPLE = 24'h444444;
  localparam logic [23:0] LBL_ORANGE = 24'h666666;
  localparam logic [23:0] LBL_YELLOW = 24'h777777;

  localparam logic [1:0] DOM_R = 2'd0;
  localparam logic [1:0] DOM_G = 2'd1;
  localparam logic [1:0] DOM_B = 2'd2;

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  // Input stage: edge detectors, counters, captured pixel and timing
  logic        de_prev_q, vs_prev_q;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic        vs_rise, de_fall;
  logic [23:0] in_rgb_q;
  logic        in_hs_q, in_vs_q, in_de_q, in_vsr_q;

  // Stage 1
  logic [7:0]  s1_r_q, s1_g_q, s1_b_q;
  logic [7:0]  s1_max_q, s1_max_d;
  logic [7:0]  s1_min_q, s1_min_d;
  logic        s1_hs_q, s1_vs_q, s1_de_q, s1_vsr_q;
  logic [11:0] s1_col_q, s1_row_q;

  // Stage 2
  logic [7:0]  s2_r_q, s2_g_q, s2_b_q, s2_max_q;
  logic [7:0]  s2_delta_q, s2_delta_d;
  logic [1:0]  s2_dom_q, s2_dom_d;
  logic        s2_hs_q, s2_vs_q, s2_de_q, s2_vsr_q;
  logic [11:0] s2_col_q, s2_row_q;

  // Stage 3 (output registers)
  logic [23:0] label_q, label_d;
  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q;
  logic [2:0]  frame_q, frame_d;
  logic        out_hs_q, out_vs_q, out_de_q;

  // Ratio terms, widened so 4*255 and 3*255 never overflow
  logic [10:0] delta_w, d_gb, d_bg, d_rb, d_br, d_rg, d_gr;

  // -------------------------------------------------------------------------
  // Input stage: column/row counters. col_q/row_q belong to the pixel
  // currently held in in_rgb_q.
  // -------------------------------------------------------------------------
  always_comb begin
    vs_rise = i_vsync & ~vs_prev_q;
    de_fall = ~i_de & de_prev_q;

    col_d = 12'd0;
    if (i_de && de_prev_q) begin
      col_d = (col_q == CNT_MAX) ? col_q : col_q + 12'd1;
    end

    // A frame start beats a line end in the same cycle
    row_d = row_q;
    if (vs_rise) begin
      row_d = 12'd0;
    end else if (de_fall && row_q != CNT_MAX) begin
      row_d = row_q + 12'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: max/min of the captured pixel
  // -------------------------------------------------------------------------
  always_comb begin
    s1_max_d = in_rgb_q[23:16];
    if (in_rgb_q[15:8] > s1_max_d) s1_max_d = in_rgb_q[15:8];
    if (in_rgb_q[7:0]  > s1_max_d) s1_max_d = in_rgb_q[7:0];
    s1_min_d = in_rgb_q[23:16];
    if (in_rgb_q[15:8] < s1_min_d) s1_min_d = in_rgb_q[15:8];
    if (in_rgb_q[7:0]  < s1_min_d) s1_min_d = in_rgb_q[7:0];
  end

  // -------------------------------------------------------------------------
  // Stage 2: chroma spread and dominant channel (ties favour R, then B over G)
  // -------------------------------------------------------------------------
  always_comb begin
    s2_delta_d = s1_max_q - s1_min_q;
    if (s1_r_q >= s1_g_q && s1_r_q >= s1_b_q) begin
      s2_dom_d = DOM_R;
    end else if (s1_g_q > s1_b_q) begin
      s2_dom_d = DOM_G;
    end else begin
      s2_dom_d = DOM_B;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: label decision. Each difference is only used when its operands
  // are in the order that makes it non-negative.
  // -------------------------------------------------------------------------
  always_comb begin
    delta_w = {3'b000, s2_delta_q};
    d_gb    = {3'b000, s2_g_q - s2_b_q};
    d_bg    = {3'b000, s2_b_q - s2_g_q};
    d_rb    = {3'b000, s2_r_q - s2_b_q};
    d_br    = {3'b000, s2_b_q - s2_r_q};
    d_rg    = {3'b000, s2_r_q - s2_g_q};
    d_gr    = {3'b000, s2_g_q - s2_r_q};

    label_d = LBL_NONE;
    if (s2_de_q && s2_delta_q >= SAT_TH && s2_max_q >= VAL_TH) begin
      case (s2_dom_q)
        DOM_R: begin
          if (s2_g_q >= s2_b_q) begin
            if ((d_gb << 2) < delta_w) begin
              label_d = LBL_RED;
            end else if (((d_gb << 1) + d_gb) < (delta_w << 1)) begin
              label_d = LBL_ORANGE;
            end else begin
              label_d = LBL_YELLOW;
            end
          end else begin
            label_d = ((d_bg << 2) < delta_w) ? LBL_RED : LBL_PURPLE;
          end
        end
        DOM_G: begin
          if (s2_r_q > s2_b_q) begin
            label_d = ((d_rb << 2) > ((delta_w << 1) + delta_w)) ? LBL_YELLOW : LBL_GREEN;
          end else begin
            // Strong blue cast on green reads as cyan: no label
            label_d = ((d_br << 1) > delta_w) ? LBL_NONE : LBL_GREEN;
          end
        end
        DOM_B: begin
          if (s2_r_q > s2_g_q) begin
            label_d = ((d_rg << 1) > delta_w) ? LBL_PURPLE : LBL_BLUE;
          end else begin
            label_d = ((d_gr << 1) > delta_w) ? LBL_NONE : LBL_BLUE;
          end
        end
        default: label_d = LBL_NONE;
      endcase
    end

    hcount_d = s2_de_q ? s2_col_q : 12'd0;
    // The frame-start flag travels with its pixel so the count steps on the
    // same edge that raises o_vsync.
    frame_d  = frame_q + {2'b00, s2_vsr_q};
  end

  // -------------------------------------------------------------------------
  // All state
  // -------------------------------------------------------------------------
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      de_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      col_q      <= 12'd0;
      row_q      <= 12'd0;
      in_rgb_q   <= 24'd0;
      in_hs_q    <= 1'b0;
      in_vs_q    <= 1'b0;
      in_de_q    <= 1'b0;
      in_vsr_q   <= 1'b0;
      s1_r_q     <= 8'd0;
      s1_g_q     <= 8'd0;
      s1_b_q     <= 8'd0;
      s1_max_q   <= 8'd0;
      s1_min_q   <= 8'd0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_de_q    <= 1'b0;
      s1_vsr_q   <= 1'b0;
      s1_col_q   <= 12'd0;
      s1_row_q   <= 12'd0;
      s2_r_q     <= 8'd0;
      s2_g_q     <= 8'd0;
      s2_b_q     <= 8'd0;
      s2_max_q   <= 8'd0;
      s2_delta_q <= 8'd0;
      s2_dom_q   <= DOM_R;
      s2_hs_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
      s2_de_q    <= 1'b0;
      s2_vsr_q   <= 1'b0;
      s2_col_q   <= 12'd0;
      s2_row_q   <= 12'd0;
      label_q    <= LBL_NONE;
      hcount_q   <= 12'd0;
      vcount_q   <= 12'd0;
      frame_q    <= 3'd0;
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
      out_de_q   <= 1'b0;
    end else begin
      de_prev_q  <= i_de;
      vs_prev_q  <= i_vsync;
      col_q      <= col_d;
      row_q      <= row_d;
      in_rgb_q   <= i_rgb;
      in_hs_q    <= i_hsync;
      in_vs_q    <= i_vsync;
      in_de_q    <= i_de;
      in_vsr_q   <= vs_rise;

      s1_r_q     <= in_rgb_q[23:16];
      s1_g_q     <= in_rgb_q[15:8];
      s1_b_q     <= in_rgb_q[7:0];
      s1_max_q   <= s1_max_d;
      s1_min_q   <= s1_min_d;
      s1_hs_q    <= in_hs_q;
      s1_vs_q    <= in_vs_q;
      s1_de_q    <= in_de_q;
      s1_vsr_q   <= in_vsr_q;
      s1_col_q   <= col_q;
      s1_row_q   <= row_q;

      s2_r_q     <= s1_r_q;
      s2_g_q     <= s1_g_q;
      s2_b_q     <= s1_b_q;
      s2_max_q   <= s1_max_q;
      s2_delta_q <= s2_delta_d;
      s2_dom_q   <= s2_dom_d;
      s2_hs_q    <= s1_hs_q;
      s2_vs_q    <= s1_vs_q;
      s2_de_q    <= s1_de_q;
      s2_vsr_q   <= s1_vsr_q;
      s2_col_q   <= s1_col_q;
      s2_row_q   <= s1_row_q;

      label_q    <= label_d;
      hcount_q   <= hcount_d;
      vcount_q   <= s2_row_q;
      frame_q    <= frame_d;
      out_hs_q   <= s2_hs_q;
      out_vs_q   <= s2_vs_q;
      out_de_q   <= s2_de_q;
    end
  end

  assign o_label     = label_q;
  assign o_hsync     = out_hs_q;
  assign o_vsync     = out_vs_q;
  assign o_de        = out_de_q;
  assign o_hcount    = hcount_q;
  assign o_vcount    = vcount_q;
  assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_color_label_encoder.sv
// ---------------------------------------------------------------------------
// tb_color_label_encoder
//
// Inputs change on the falling clock edge. On every rising edge (reset
// released) the expected output record for the sampled inputs is pushed to
// a scoreboard queue; the queue is primed with three all-zero records, so on
// every falling edge the front record belongs to the pixel sampled three
// edges earlier and is compared against all o_* ports.
// ---------------------------------------------------------------------------
module tb_color_label_encoder;

  logic        pixelclk = 1'b0;
  logic        reset_n  = 1'b1;
  logic [23:0] i_rgb    = 24'd0;
  logic        i_hsync  = 1'b0;
  logic        i_vsync  = 1'b0;
  logic        i_de     = 1'b0;
  logic [23:0] o_label;
  logic        o_hsync, o_vsync, o_de;
  logic [11:0] o_hcount, o_vcount;
  logic [2:0]  o_frame_cnt;

  always #5 pixelclk = ~pixelclk;

  color_label_encoder dut (
    .pixelclk    (pixelclk),
    .reset_n     (reset_n),
    .i_rgb       (i_rgb),
    .i_hsync     (i_hsync),
    .i_vsync     (i_vsync),
    .i_de        (i_de),
    .o_label     (o_label),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_de        (o_de),
    .o_hcount    (o_hcount),
    .o_vcount    (o_vcount),
    .o_frame_cnt (o_frame_cnt)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [23:0] label;
    logic        hs, vs, de;
    logic [11:0] hc, vc;
    logic [2:0]  fc;
    int          id;
  } exp_t;

  typedef struct {
    logic [23:0] rgb;
    logic        de;
    logic [23:0] label;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Expected label for the pixel being driven, and its table index (-1: none)
  logic [23:0] exp_lab = 24'd0;
  int          cur_id  = -1;

  // Counter model
  logic        m_de_prev = 1'b0, m_vs_prev = 1'b0;
  logic [11:0] m_col = 12'd0, m_row = 12'd0;
  logic [2:0]  m_frame = 3'd0;

  // Reference classifier written straight from the colour rules, in ints
  function automatic logic [23:0] ref_label(input logic [23:0] rgb);
    int r, g, b, mx, mn, dl;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    dl = mx - mn;
    if (dl < 40 || mx < 50) return 24'h000000;
    if (r >= g && r >= b) begin
      if (g >= b) begin
        if (4 * (g - b) < dl) return 24'h333333;
        if (3 * (g - b) < 2 * dl) return 24'h666666;
        return 24'h777777;
      end
      return (4 * (b - g) < dl) ? 24'h333333 : 24'h444444;
    end
    if (g > b) begin
      if (r > b) return (4 * (r - b) > 3 * dl) ? 24'h777777 : 24'h222222;
      return (2 * (b - r) > dl) ? 24'h000000 : 24'h222222;
    end
    if (r > g) return (2 * (r - g) > dl) ? 24'h444444 : 24'h111111;
    return (2 * (g - r) > dl) ? 24'h000000 : 24'h111111;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t zero_rec();
    exp_t e;
    e.rgb = 24'd0; e.label = 24'd0;
    e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0;
    e.hc = 12'd0; e.vc = 12'd0; e.fc = 3'd0;
    e.id = -1;
    return e;
  endfunction

  // Called while reset is low: pipeline drains to zeros, counters restart
  task automatic clear_model();
    sb_q.delete();
    repeat (3) sb_q.push_back(zero_rec());
    m_de_prev = 1'b0; m_vs_prev = 1'b0;
    m_col = 12'd0; m_row = 12'd0; m_frame = 3'd0;
  endtask

  task automatic drive(input logic [23:0] rgb, input logic hs, input logic vs,
                       input logic de, input logic [23:0] lab, input int id);
    @(negedge pixelclk);
    i_rgb = rgb; i_hsync = hs; i_vsync = vs; i_de = de;
    exp_lab = lab; cur_id = id;
  endtask

  task automatic drive_px(input logic [23:0] rgb, input logic hs, input logic vs, input logic de);
    drive(rgb, hs, vs, de, de ? ref_label(rgb) : 24'h000000, -1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_label"}, {8'h00, o_label}, 32'd0);
    chk({tag, "_sync"},  {29'd0, o_hsync, o_vsync, o_de}, 32'd0);
    chk({tag, "_hcount"}, {20'd0, o_hcount}, 32'd0);
    chk({tag, "_vcount"}, {20'd0, o_vcount}, 32'd0);
    chk({tag, "_frame"}, {29'd0, o_frame_cnt}, 32'd0);
  endtask

  // Sampler: builds the expected record for each sampled input
  exp_t smp_e;
  logic smp_rise, smp_fall;
  initial begin
    forever begin
      @(posedge pixelclk);
      if (reset_n) begin
        smp_rise = i_vsync && !m_vs_prev;
        smp_fall = !i_de && m_de_prev;
        if (!i_de) m_col = 12'd0;
        else if (!m_de_prev) m_col = 12'd0;
        else if (m_col != 12'hFFF) m_col = m_col + 12'd1;
        if (smp_rise) m_row = 12'd0;
        else if (smp_fall && m_row != 12'hFFF) m_row = m_row + 12'd1;
        if (smp_rise) m_frame = m_frame + 3'd1;
        m_de_prev = i_de;
        m_vs_prev = i_vsync;
        smp_e.rgb   = i_rgb;
        smp_e.label = i_de ? exp_lab : 24'h000000;
        smp_e.hs    = i_hsync;
        smp_e.vs    = i_vsync;
        smp_e.de    = i_de;
        smp_e.hc    = i_de ? m_col : 12'd0;
        smp_e.vc    = m_row;
        smp_e.fc    = m_frame;
        smp_e.id    = cur_id;
        sb_q.push_back(smp_e);
      end
    end
  end

  // Checker: compares the record due three edges after it was sampled
  exp_t ce;
  initial begin
    forever begin
      @(negedge pixelclk);
      if (reset_n && sb_q.size() >= 4) begin
        ce = sb_q.pop_front();
        chk("label",  {8'h00, o_label}, {8'h00, ce.label});
        chk("timing", {29'd0, o_hsync, o_vsync, o_de}, {29'd0, ce.hs, ce.vs, ce.de});
        chk("hcount", {20'd0, o_hcount}, {20'd0, ce.hc});
        chk("vcount", {20'd0, o_vcount}, {20'd0, ce.vc});
        chk("frame",  {29'd0, o_frame_cnt}, {29'd0, ce.fc});
        if (ce.id >= 0)
          $display("txn %0d rgb %h de %0b label %h want %h", ce.id, ce.rgb, ce.de, o_label, ce.label);
      end
    end
  end

  initial begin
    clear_model();

    vecs[0]  = '{24'hFF0000, 1'b1, 24'h333333};
    vecs[1]  = '{24'h00FF00, 1'b1, 24'h222222};
    vecs[2]  = '{24'h0000FF, 1'b1, 24'h111111};
    vecs[3]  = '{24'hFFFF00, 1'b1, 24'h777777};
    vecs[4]  = '{24'hFF8000, 1'b1, 24'h666666};
    vecs[5]  = '{24'h800080, 1'b1, 24'h444444};
    vecs[6]  = '{24'h808080, 1'b1, 24'h000000};
    vecs[7]  = '{24'h200000, 1'b1, 24'h000000};
    vecs[8]  = '{24'h00FFFF, 1'b1, 24'h000000};
    vecs[9]  = '{24'hFF0000, 1'b0, 24'h000000};
    vecs[10] = '{24'hFF4000, 1'b1, 24'h666666};
    vecs[11] = '{24'hFF3000, 1'b1, 24'h333333};
    vecs[12] = '{24'hFFE000, 1'b1, 24'h777777};
    vecs[13] = '{24'hFF00C0, 1'b1, 24'h444444};
    vecs[14] = '{24'hFF0030, 1'b1, 24'h333333};
    vecs[15] = '{24'h40FF00, 1'b1, 24'h222222};
    vecs[16] = '{24'hE0FF00, 1'b1, 24'h777777};
    vecs[17] = '{24'h10FF80, 1'b1, 24'h222222};
    vecs[18] = '{24'h00FF80, 1'b1, 24'h000000};
    vecs[19] = '{24'h8000FF, 1'b1, 24'h444444};
    vecs[20] = '{24'h3000FF, 1'b1, 24'h111111};
    vecs[21] = '{24'h323200, 1'b1, 24'h777777};
    vecs[22] = '{24'h313100, 1'b1, 24'h000000};
    vecs[23] = '{24'h503C28, 1'b1, 24'h666666};
    vecs[24] = '{24'h503C29, 1'b1, 24'h000000};
    vecs[25] = '{24'h00FF00, 1'b0, 24'h000000};
    vecs[26] = '{24'h0000FF, 1'b1, 24'h111111};

    // Power-on reset
    #1 reset_n = 1'b0;
    #11 check_all_zero("por");
    repeat (2) @(negedge pixelclk);
    reset_n = 1'b1;

    // Colour table, one pixel per cycle
    for (int i = 0; i < NV; i++) drive(vecs[i].rgb, 1'b0, 1'b0, vecs[i].de, vecs[i].label, i);
    repeat (3) drive_px(24'h000000, 1'b0, 1'b0, 1'b0);

    // Counters: vsync pulse, then 3 lines of 4 pixels with hsync in blanking
    drive_px(24'h000000, 1'b0, 1'b1, 1'b0);
    drive_px(24'h000000, 1'b0, 1'b0, 1'b0);
    for (int ln = 0; ln < 3; ln++) begin
      for (int px = 0; px < 4; px++) drive_px(24'($urandom), 1'b0, 1'b0, 1'b1);
      drive_px(24'h000000, 1'b1, 1'b0, 1'b0);
      drive_px(24'h000000, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a line with data in flight
    for (int px = 0; px < 5; px++) drive_px(24'hFF0000, 1'b0, 1'b0, 1'b1);
    @(posedge pixelclk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    clear_model();
    repeat (2) @(negedge pixelclk);
    reset_n = 1'b1;
    for (int px = 0; px < 3; px++) drive_px(24'h00FF00, 1'b0, 1'b0, 1'b1);
    repeat (2) drive_px(24'h000000, 1'b0, 1'b0, 1'b0);

    // Nine frame starts; two-cycle vsync must count once
    for (int f = 0; f < 9; f++) begin
      repeat (2) drive_px(24'h000000, 1'b0, 1'b1, 1'b0);
      drive_px(24'h0000FF, 1'b0, 1'b0, 1'b1);
      repeat (2) drive_px(24'h000000, 1'b0, 1'b0, 1'b0);
    end

    // Random timing and pixels
    begin
      logic de_r;
      de_r = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 5) == 0) de_r = ~de_r;
        drive_px(24'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0), de_r);
      end
    end

    // Drain the pipeline
    repeat (4) drive_px(24'h000000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge pixelclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
